// File: rtl/pulse_train_if.sv
// pulse_train_if: launch/config/abort inputs and pulse/status outputs of the pulse train stage
interface pulse_train_if #(
    parameter int CNT_W = 35,
    parameter int NUM_W = 16
);
    logic             launch_PL;
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] period;
    logic [NUM_W-1:0] count;
    logic             stop_PL;
    logic             PL_out;
    logic             busy;
    logic             done_PL;
    logic             cfg_err;
    modport slave (
        input  launch_PL, width, period, count, stop_PL,
        output PL_out, busy, done_PL, cfg_err
    );
    modport master (
        output launch_PL, width, period, count, stop_PL,
        input  PL_out, busy, done_PL, cfg_err
    );
endinterface

// File: rtl/pulse_train.sv
// pulse_train: emits count pulses of width cycles at period spacing on each launch_PL rising edge
module pulse_train #(
    parameter int CNT_W = 35,
    parameter int NUM_W = 16
) (
    input  logic          clk_PL,
    input  logic          rst_PL,
    pulse_train_if.slave  io
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW, WAIT_REL} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] ph_q, ph_d, w_q, w_d, p_q, p_d;
    logic [NUM_W-1:0] n_q, n_d;
    logic             launch_q, pl_q, pl_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic             trig, cfg_ok, last_ph;
    assign trig    = io.launch_PL & ~launch_q;
    assign cfg_ok  = io.width != '0 && io.count != '0 && io.period > io.width;
    assign last_ph = ph_q == '0;
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        w_d     = w_q;
        p_d     = p_q;
        n_d     = n_q;
        pl_d    = pl_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (trig && !io.stop_PL) begin
                w_d     = io.width;
                p_d     = io.period;
                n_d     = io.count;
                ph_d    = io.width - CNT_W'(1);
                pl_d    = cfg_ok;
                err_d   = !cfg_ok;
                state_d = cfg_ok ? HIGH : WAIT_REL;
            end
            HIGH: if (io.stop_PL) begin
                pl_d    = 1'b0;
                state_d = WAIT_REL;
            end else if (last_ph) begin
                pl_d = 1'b0;
                // a finished train skips WAIT_REL when launch is already low so the next edge is not missed
                if (n_q == NUM_W'(1)) begin
                    done_d  = 1'b1;
                    state_d = io.launch_PL ? WAIT_REL : IDLE;
                end else begin
                    ph_d    = p_q - w_q - CNT_W'(1);
                    n_d     = n_q - NUM_W'(1);
                    state_d = LOW;
                end
            end else begin
                ph_d = ph_q - CNT_W'(1);
            end
            LOW: if (io.stop_PL) begin
                state_d = WAIT_REL;
            end else if (last_ph) begin
                pl_d    = 1'b1;
                ph_d    = w_q - CNT_W'(1);
                state_d = HIGH;
            end else begin
                ph_d = ph_q - CNT_W'(1);
            end
            WAIT_REL: state_d = io.launch_PL ? WAIT_REL : IDLE;
        endcase
        busy_d = state_d == HIGH || state_d == LOW;
    end
    always_ff @(posedge clk_PL or posedge rst_PL) begin
        if (rst_PL) begin
            state_q  <= IDLE;
            ph_q     <= '0;
            w_q      <= '0;
            p_q      <= '0;
            n_q      <= '0;
            launch_q <= 1'b1;
            pl_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            w_q      <= w_d;
            p_q      <= p_d;
            n_q      <= n_d;
            launch_q <= io.launch_PL;
            pl_q     <= pl_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end
    assign io.PL_out  = pl_q;
    assign io.busy    = busy_q;
    assign io.done_PL = done_q;
    assign io.cfg_err = err_q;
endmodule

// File: tb/tb_pulse_train.sv
// tb_pulse_train: table, hand-written corner sequences and randomized trains against a waveform model
module tb_pulse_train;
    logic clk_PL = 1'b0;
    logic rst_PL = 1'b1;
    int   vecs = 0;
    int   miss = 0;
    pulse_train_if #(.CNT_W(35), .NUM_W(16)) bus ();
    pulse_train #(.CNT_W(35), .NUM_W(16)) dut (.clk_PL(clk_PL), .rst_PL(rst_PL), .io(bus));
    always #5 clk_PL = ~clk_PL;

    typedef struct {
        int w, p, n;
        int err, dones, highs, busy_n;
    } vec_t;
    vec_t tbl[9];

    task automatic tick();
        @(posedge clk_PL);
        #1;
    endtask

    task automatic chk(string nm, int act, int exp);
        vecs++;
        if (act != exp) begin
            miss++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cfg(int w, int p, int n);
        bus.width  = 35'(w);
        bus.period = 35'(p);
        bus.count  = 16'(n);
    endtask

    task automatic run(int cyc, output int highs, output int busy_n, output int dones, output int errs);
        highs = 0; busy_n = 0; dones = 0; errs = 0;
        for (int k = 0; k < cyc; k++) begin
            tick();
            highs  += int'(bus.PL_out);
            busy_n += int'(bus.busy);
            dones  += int'(bus.done_PL);
            errs   += int'(bus.cfg_err);
        end
    endtask

    function automatic void model(int w, int p, int n, int k,
                                  output bit pl, output bit busy, output bit done, output bit err);
        bit v;
        int tot;
        v    = w != 0 && n != 0 && p > w;
        pl   = 0; busy = 0; done = 0;
        err  = !v && k == 1;
        if (v) begin
            tot  = (n - 1) * p + w;
            pl   = (k - 1) / p < n && (k - 1) % p < w;
            busy = k >= 1 && k <= tot;
            done = k == tot + 1;
        end
    endfunction

    initial begin
        int h, b, d, e;
        tbl[0] = '{3, 5, 2, 0, 1, 6, 8};
        tbl[1] = '{1, 2, 4, 0, 1, 4, 7};
        tbl[2] = '{0, 5, 1, 1, 0, 0, 0};
        tbl[3] = '{4, 4, 1, 1, 0, 0, 0};
        tbl[4] = '{2, 4, 0, 1, 0, 0, 0};
        tbl[5] = '{2, 4, 1, 0, 1, 2, 2};
        tbl[6] = '{2, 3, 3, 0, 1, 6, 8};
        tbl[7] = '{5, 6, 1, 0, 1, 5, 5};
        tbl[8] = '{6, 3, 2, 1, 0, 0, 0};
        bus.launch_PL = 1'b0;
        bus.stop_PL   = 1'b0;
        cfg(0, 0, 0);
        repeat (2) @(posedge clk_PL);
        #1;
        chk("rst_pl", int'(bus.PL_out), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done_PL), 0);
        chk("rst_err", int'(bus.cfg_err), 0);
        rst_PL = 1'b0;
        tick();

        foreach (tbl[i]) begin
            cfg(tbl[i].w, tbl[i].p, tbl[i].n);
            bus.launch_PL = 1'b1;
            run(20, h, b, d, e);
            chk($sformatf("tbl%0d_err", i), e, tbl[i].err);
            chk($sformatf("tbl%0d_done", i), d, tbl[i].dones);
            chk($sformatf("tbl%0d_highs", i), h, tbl[i].highs);
            chk($sformatf("tbl%0d_busy", i), b, tbl[i].busy_n);
            bus.launch_PL = 1'b0;
            repeat (2) tick();
        end

        // exact waveform of the basic train, with inputs scrambled after the trigger
        cfg(3, 5, 2);
        bus.launch_PL = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) cfg(0, 1, 0);
            chk($sformatf("wave1_pl_c%0d", k), int'(bus.PL_out), int'((k >= 1 && k <= 3) || (k >= 6 && k <= 8)));
            chk($sformatf("wave1_busy_c%0d", k), int'(bus.busy), int'(k <= 8));
            chk($sformatf("wave1_done_c%0d", k), int'(bus.done_PL), int'(k == 9));
        end
        bus.launch_PL = 1'b0;
        repeat (2) tick();

        cfg(1, 2, 4);
        bus.launch_PL = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk($sformatf("wave2_pl_c%0d", k), int'(bus.PL_out), int'(k <= 7 && k % 2 == 1));
            chk($sformatf("wave2_done_c%0d", k), int'(bus.done_PL), int'(k == 8));
        end
        bus.launch_PL = 1'b0;
        repeat (2) tick();

        // held launch gives one train; a one-cycle drop re-arms
        cfg(2, 4, 1);
        bus.launch_PL = 1'b1;
        run(50, h, b, d, e);
        chk("hold_highs", h, 2);
        chk("hold_done", d, 1);
        bus.launch_PL = 1'b0;
        tick();
        bus.launch_PL = 1'b1;
        run(10, h, b, d, e);
        chk("retrig_highs", h, 2);
        chk("retrig_done", d, 1);
        bus.launch_PL = 1'b0;
        repeat (2) tick();

        // abort during the gap
        cfg(5, 10, 3);
        bus.launch_PL = 1'b1;
        repeat (7) tick();
        chk("stop_busy_c7", int'(bus.busy), 1);
        bus.stop_PL = 1'b1;
        tick();
        chk("stop_pl_c8", int'(bus.PL_out), 0);
        chk("stop_busy_c8", int'(bus.busy), 0);
        chk("stop_done_c8", int'(bus.done_PL), 0);
        bus.stop_PL = 1'b0;
        run(30, h, b, d, e);
        chk("stop_after_highs", h, 0);
        chk("stop_after_done", d, 0);
        bus.launch_PL = 1'b0;
        repeat (2) tick();
        bus.launch_PL = 1'b1;
        tick();
        chk("stop_rearm_pl", int'(bus.PL_out), 1);
        run(30, h, b, d, e);
        chk("stop_rearm_done", d, 1);
        bus.launch_PL = 1'b0;
        repeat (2) tick();

        // stop coincident with a trigger in IDLE
        cfg(0, 0, 0);
        bus.stop_PL   = 1'b1;
        bus.launch_PL = 1'b1;
        tick();
        chk("idle_stop_err", int'(bus.cfg_err), 0);
        chk("idle_stop_busy", int'(bus.busy), 0);
        bus.stop_PL = 1'b0;
        cfg(2, 4, 1);
        run(6, h, b, d, e);
        chk("idle_stop_highs", h, 0);
        bus.launch_PL = 1'b0;
        repeat (2) tick();

        // asynchronous reset mid-pulse, launch held through release
        cfg(5, 10, 1);
        bus.launch_PL = 1'b1;
        repeat (2) tick();
        chk("arst_pre_pl", int'(bus.PL_out), 1);
        #1 rst_PL = 1'b1;
        #1;
        chk("arst_pl", int'(bus.PL_out), 0);
        chk("arst_busy", int'(bus.busy), 0);
        tick();
        rst_PL = 1'b0;
        run(12, h, b, d, e);
        chk("arst_held_highs", h, 0);
        bus.launch_PL = 1'b0;
        tick();
        bus.launch_PL = 1'b1;
        run(8, h, b, d, e);
        chk("arst_rearm_highs", h, 5);
        chk("arst_rearm_done", d, 1);
        bus.launch_PL = 1'b0;
        repeat (2) tick();

        for (int t = 0; t < 40; t++) begin
            int  w, p, n, hold, tot, last;
            bit  epl, ebusy, edone, eerr;
            w    = $urandom_range(0, 6);
            p    = $urandom_range(0, 10);
            n    = $urandom_range(0, 4);
            hold = $urandom_range(1, 40);
            tot  = (w != 0 && n != 0 && p > w) ? (n - 1) * p + w + 1 : 1;
            last = (hold > tot ? hold : tot) + 2;
            cfg(w, p, n);
            bus.launch_PL = 1'b1;
            for (int k = 1; k <= last; k++) begin
                tick();
                if (k == 1) cfg($urandom_range(0, 6), $urandom_range(0, 10), $urandom_range(0, 4));
                model(w, p, n, k, epl, ebusy, edone, eerr);
                chk($sformatf("rnd%0d_w%0d_p%0d_n%0d_pl_c%0d", t, w, p, n, k), int'(bus.PL_out), int'(epl));
                chk($sformatf("rnd%0d_busy_c%0d", t, k), int'(bus.busy), int'(ebusy));
                chk($sformatf("rnd%0d_done_c%0d", t, k), int'(bus.done_PL), int'(edone));
                chk($sformatf("rnd%0d_err_c%0d", t, k), int'(bus.cfg_err), int'(eerr));
                if (k == hold) bus.launch_PL = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
